// File: rtl/lcd_pixel_feeder.sv
// AXI-Stream to LCD pixel feeder: FIFO, frame-start alignment, timing-generator start and registered panel outputs.
// Optional colour-bar generator enabled by defining LCD_TEST_PATTERN_EN.
module lcd_pixel_feeder #(
  parameter int                    DATA_WIDTH      = 24,
  parameter int                    FIFO_DEPTH      = 16,
  parameter int                    START_LEVEL     = 8,
  parameter int                    H_PIXEL_COUNT   = 800,
  parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            frame_start_i,
  output logic                            tg_start_o,
  input  logic                            tg_busy_i,
  input  logic                            tg_hsync_i,
  input  logic                            tg_vsync_i,
  input  logic                            tg_enable_i,
  input  logic                            tg_hline_last_i,
  output logic [DATA_WIDTH-1:0]           lcd_data_o,
  output logic                            lcd_de_o,
  output logic                            lcd_hsync_o,
  output logic                            lcd_vsync_o,
  output logic                            underflow_o,
  input  logic                            underflow_clr_i,
`ifdef LCD_TEST_PATTERN_EN
  input  logic                            test_pattern_i,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic [1:0]                      fsm_state_o,
  output logic                            frame_err_o,
  output logic                            head_tlast_o,
  output logic                            line_end_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if ((H_PIXEL_COUNT % 8) != 0 || FIFO_DEPTH < 4 || START_LEVEL < 1 || START_LEVEL > FIFO_DEPTH)
  begin : g_bad_param
    $error("lcd_pixel_feeder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state;

  // FIFO entry layout: {tlast, tuser, tdata}
  logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH+1:0] head;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_user;

  logic [DATA_WIDTH-1:0] pixel;
  logic                  uf_set;
  logic                  err_set;
  logic                  first_pix;
  logic                  busy_q;
  logic                  frame_err;
  logic                  use_pattern;
  logic [DATA_WIDTH-1:0] bar_color;

  assign full          = (level == LW'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign s_axis_tready = ~full & ~rst_i;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign head          = mem[rd_ptr];
  assign head_data     = head[DATA_WIDTH-1:0];
  assign head_user     = head[DATA_WIDTH];
  assign head_tlast_o  = head[DATA_WIDTH+1];
  assign fifo_level_o  = level;
  assign fsm_state_o   = state;
  assign frame_err_o   = frame_err;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int CW    = $clog2(H_PIXEL_COUNT) + 1;
  localparam int BAR_W = H_PIXEL_COUNT / 8;

  logic [CW-1:0] col;
  logic [CW-1:0] bar_raw;
  logic [2:0]    bar_sel;

  assign use_pattern = test_pattern_i;
  assign bar_raw     = col / CW'(BAR_W);
  assign bar_sel     = (bar_raw > CW'(7)) ? 3'd7 : bar_raw[2:0];

  // Column restarts on the generator's line-end marker, otherwise advances per enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col <= '0;
    end else if (tg_hline_last_i) begin
      col <= '0;
    end else if (tg_enable_i) begin
      col <= col + 1'b1;
    end
  end

  always_comb begin
    bar_color = '0;
    case (bar_sel)
      3'd0:    bar_color = DATA_WIDTH'(24'hFFFFFF);
      3'd1:    bar_color = DATA_WIDTH'(24'hFFFF00);
      3'd2:    bar_color = DATA_WIDTH'(24'h00FFFF);
      3'd3:    bar_color = DATA_WIDTH'(24'h00FF00);
      3'd4:    bar_color = DATA_WIDTH'(24'hFF00FF);
      3'd5:    bar_color = DATA_WIDTH'(24'hFF0000);
      3'd6:    bar_color = DATA_WIDTH'(24'h0000FF);
      default: bar_color = DATA_WIDTH'(24'h000000);
    endcase
  end
`else
  assign use_pattern = 1'b0;
  assign bar_color   = '0;
`endif

  // Pop/pixel selection. In SYNC, stale beats ahead of a frame start are dropped.
  always_comb begin
    pop     = 1'b0;
    pixel   = '0;
    uf_set  = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_SYNC: begin
        if (!empty && !head_user) pop = 1'b1;
      end
      ST_RUN: begin
        if (tg_enable_i) begin
          if (use_pattern) begin
            pixel = bar_color;
          end else if (!empty) begin
            pop   = 1'b1;
            pixel = head_data;
            if (head_user && !first_pix) err_set = 1'b1;
          end else begin
            pixel   = UNDERFLOW_COLOR;
            uf_set  = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_SYNC;
      tg_start_o <= 1'b0;
      first_pix  <= 1'b0;
      frame_err  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q     <= tg_busy_i;
      tg_start_o <= 1'b0;
      case (state)
        ST_SYNC: begin
          if (!empty && head_user) state <= ST_ARM;
        end
        ST_ARM: begin
          if (frame_start_i && (level >= LW'(START_LEVEL)) && !tg_busy_i) begin
            tg_start_o <= 1'b1;
            first_pix  <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tg_enable_i) first_pix <= 1'b0;
          if (err_set) frame_err <= 1'b1;
          // Frame is over when the generator drops busy; realign on the next SOF.
          if (busy_q && !tg_busy_i) begin
            frame_err <= 1'b0;
            state     <= ST_SYNC;
          end
        end
        default: begin
          state <= ST_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lcd_data_o  <= '0;
      lcd_de_o    <= 1'b0;
      lcd_hsync_o <= 1'b1;
      lcd_vsync_o <= 1'b1;
      line_end_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      lcd_data_o  <= tg_enable_i ? pixel : '0;
      lcd_de_o    <= tg_enable_i;
      lcd_hsync_o <= tg_hsync_i;
      lcd_vsync_o <= tg_vsync_i;
      line_end_o  <= tg_hline_last_i;
      if (uf_set) begin
        underflow_o <= 1'b1;
      end else if (underflow_clr_i) begin
        underflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Directed bench for lcd_pixel_feeder: frames of 8x4 pixels through a behavioural timing generator.
module tb_lcd_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [23:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        frame_start_i;
  logic        tg_start_o;
  logic        tg_busy_i;
  logic        tg_hsync_i;
  logic        tg_vsync_i;
  logic        tg_enable_i;
  logic        tg_hline_last_i;
  logic [23:0] lcd_data_o;
  logic        lcd_de_o;
  logic        lcd_hsync_o;
  logic        lcd_vsync_o;
  logic        underflow_o;
  logic        underflow_clr_i;
  logic [4:0]  fifo_level_o;
  logic [1:0]  fsm_state_o;
  logic        frame_err_o;
  logic        head_tlast_o;
  logic        line_end_o;
`ifdef LCD_TEST_PATTERN_EN
  logic        test_pattern_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int start_level = 0;
  logic mon_en = 1'b0;
  logic [23:0] exp_q[$];

  lcd_pixel_feeder #(
    .DATA_WIDTH(24), .FIFO_DEPTH(16), .START_LEVEL(8), .H_PIXEL_COUNT(8),
    .UNDERFLOW_COLOR(24'hFF00FF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .frame_start_i(frame_start_i), .tg_start_o(tg_start_o), .tg_busy_i(tg_busy_i),
    .tg_hsync_i(tg_hsync_i), .tg_vsync_i(tg_vsync_i), .tg_enable_i(tg_enable_i),
    .tg_hline_last_i(tg_hline_last_i),
    .lcd_data_o(lcd_data_o), .lcd_de_o(lcd_de_o), .lcd_hsync_o(lcd_hsync_o), .lcd_vsync_o(lcd_vsync_o),
    .underflow_o(underflow_o), .underflow_clr_i(underflow_clr_i),
`ifdef LCD_TEST_PATTERN_EN
    .test_pattern_i(test_pattern_i),
`endif
    .fifo_level_o(fifo_level_o), .fsm_state_o(fsm_state_o), .frame_err_o(frame_err_o),
    .head_tlast_o(head_tlast_o), .line_end_o(line_end_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every displayed pixel must match the head of exp_q.
  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      if (tg_start_o) begin
        start_cnt++;
        start_level = int'(fifo_level_o);
      end
      if (lcd_de_o) begin
        if (exp_q.size() == 0) check_val("extra_de", 1, 0);
        else check_val("pixel", lcd_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [23:0] d, input logic u, input logic l);
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check_val("tready_timeout", 0, 1);
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic push_range(input logic [23:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) push_beat(base + 24'(i), i == 0, (i % 8) == 7);
  endtask

  task automatic expect_range(input logic [23:0] base, input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(base + 24'(i));
  endtask

  // Behavioural timing generator: 4 lines of 8 active pixels after a start pulse.
  task automatic tg_frame(input int exp_starts);
    int n = 0;
    while (start_cnt < exp_starts && n < 500) begin
      tick();
      n++;
    end
    if (start_cnt < exp_starts) begin
      check_val("start_timeout", start_cnt, exp_starts);
      return;
    end
    tg_busy_i = 1'b1;
    for (int l = 0; l < 4; l++) begin
      tg_hsync_i = 1'b0;
      tg_vsync_i = (l == 0) ? 1'b0 : 1'b1;
      tick();
      tick();
      tg_hsync_i = 1'b1;
      tg_vsync_i = 1'b1;
      tick();
      tg_enable_i = 1'b1;
      repeat (8) tick();
      tg_enable_i     = 1'b0;
      tg_hline_last_i = 1'b1;
      tick();
      tg_hline_last_i = 1'b0;
    end
    tg_busy_i = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst_i = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    frame_start_i = 1'b1; tg_busy_i = 1'b0; tg_hsync_i = 1'b1; tg_vsync_i = 1'b1;
    tg_enable_i = 1'b0; tg_hline_last_i = 1'b0; underflow_clr_i = 1'b0;
`ifdef LCD_TEST_PATTERN_EN
    test_pattern_i = 1'b0;
`endif
    repeat (3) tick();
    check_val("rst_data", lcd_data_o, 0);
    check_val("rst_de", lcd_de_o, 0);
    check_val("rst_hsync", lcd_hsync_o, 1);
    check_val("rst_vsync", lcd_vsync_o, 1);
    check_val("rst_start", tg_start_o, 0);
    check_val("rst_underflow", underflow_o, 0);
    check_val("rst_level", fifo_level_o, 0);
    check_val("rst_tready", s_axis_tready, 0);
    check_val("rst_state", fsm_state_o, 0);
    rst_i = 1'b0;
    mon_en = 1'b1;
    tick();
    check_val("tready_idle", s_axis_tready, 1);

    // Sync passthrough with one cycle of latency
    tg_hsync_i = 1'b0; tg_vsync_i = 1'b0;
    tick();
    check_val("hsync_pass", lcd_hsync_o, 0);
    check_val("vsync_pass", lcd_vsync_o, 0);
    tg_hsync_i = 1'b1; tg_vsync_i = 1'b1;
    tick();
    check_val("hsync_back", lcd_hsync_o, 1);

    // 1: aligned frame 0..31; start fires when ARM sees 8 beats (level 9 after that edge)
    expect_range(24'h0, 0, 31);
    fork
      push_range(24'h0, 0, 31);
      tg_frame(1);
    join
    check_val("t1_starts", start_cnt, 1);
    check_val("t1_start_level", start_level, 9);
    check_val("t1_left", exp_q.size(), 0);
    check_val("t1_state", fsm_state_o, 0);

    // 2: three stray beats ahead of SOF are dropped; level 7 must not start
    push_beat(24'hAA, 1'b0, 1'b0);
    push_beat(24'hBB, 1'b0, 1'b0);
    push_beat(24'hCC, 1'b0, 1'b0);
    push_range(24'h100, 0, 6);
    repeat (5) tick();
    check_val("t2_level7", fifo_level_o, 7);
    check_val("t2_state_arm", fsm_state_o, 1);
    check_val("t2_no_start", start_cnt, 1);
    expect_range(24'h100, 0, 31);
    fork
      push_range(24'h100, 7, 31);
      tg_frame(2);
    join
    check_val("t2_left", exp_q.size(), 0);

    // 3: source stops after 20 beats; remainder shows the underflow colour
    expect_range(24'h200, 0, 19);
    for (int i = 0; i < 12; i++) exp_q.push_back(24'hFF00FF);
    fork
      push_range(24'h200, 0, 19);
      tg_frame(3);
    join
    check_val("t3_left", exp_q.size(), 0);
    check_val("t3_underflow", underflow_o, 1);
    tick();
    check_val("t3_sticky", underflow_o, 1);
    underflow_clr_i = 1'b1;
    tick();
    underflow_clr_i = 1'b0;
    check_val("t3_cleared", underflow_o, 0);
    expect_range(24'h300, 0, 31);
    fork
      push_range(24'h300, 0, 31);
      tg_frame(4);
    join
    check_val("t3b_left", exp_q.size(), 0);
    check_val("t3b_no_underflow", underflow_o, 0);

    // 4: sink stalled; FIFO fills to 16 and backpressures
    frame_start_i = 1'b0;
    push_range(24'h400, 0, 15);
    repeat (4) tick();
    check_val("t4_level", fifo_level_o, 16);
    check_val("t4_tready", s_axis_tready, 0);
    check_val("t4_state_arm", fsm_state_o, 1);
    check_val("t4_no_start", start_cnt, 4);
    expect_range(24'h400, 0, 31);
    frame_start_i = 1'b1;
    fork
      push_range(24'h400, 16, 31);
      tg_frame(5);
    join
    check_val("t4_left", exp_q.size(), 0);

    // 5: reset asserted while pixel 9 is on the panel
    push_range(24'h500, 0, 15);
    begin
      int n = 0;
      while (start_cnt < 6 && n < 100) begin
        tick();
        n++;
      end
    end
    check_val("t5_started", start_cnt, 6);
    expect_range(24'h500, 0, 8);
    tg_busy_i = 1'b1;
    tg_hsync_i = 1'b0; tg_vsync_i = 1'b0;
    tick();
    tg_hsync_i = 1'b1; tg_vsync_i = 1'b1;
    tg_enable_i = 1'b1;
    repeat (10) tick();
    check_val("t5_pre_de", lcd_de_o, 1);
    check_val("t5_pre_pix9", lcd_data_o, 24'h509);
    rst_i = 1'b1;
    #1;
    check_val("t5_rst_de", lcd_de_o, 0);
    check_val("t5_rst_data", lcd_data_o, 0);
    check_val("t5_rst_hsync", lcd_hsync_o, 1);
    check_val("t5_rst_vsync", lcd_vsync_o, 1);
    check_val("t5_rst_level", fifo_level_o, 0);
    check_val("t5_rst_state", fsm_state_o, 0);
    tg_enable_i = 1'b0; tg_busy_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    check_val("t5_left", exp_q.size(), 0);
    check_val("t5_level_after", fifo_level_o, 0);
    expect_range(24'h600, 0, 31);
    fork
      push_range(24'h600, 0, 31);
      tg_frame(7);
    join
    check_val("t5b_left", exp_q.size(), 0);

`ifdef LCD_TEST_PATTERN_EN
    // 6: colour bars, FIFO untouched
    begin
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      test_pattern_i = 1'b1;
      push_range(24'h700, 0, 15);
      frame_start_i = 1'b0;
      for (int l = 0; l < 4; l++)
        for (int c = 0; c < 8; c++) exp_q.push_back(bars[c]);
      tg_frame(8);
      check_val("t6_left", exp_q.size(), 0);
      check_val("t6_level", fifo_level_o, 16);
      check_val("t6_no_underflow", underflow_o, 0);
      test_pattern_i = 1'b0;
    end
`endif

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
